// File: rtl/lb_master.sv
// lb_master: localbus initiator driving one four-phase cs_n/ack_n transfer at a time.
// Define LB_MASTER_STATS_EN to add read/write/timeout completion counters.
module lb_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              ctrl_valid,
    output logic              ctrl_cs_n,
    output logic              ctrl_cmd,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [DATA_W-1:0] ctrl_dataout,
    input  logic              ctrl_ack_n,
    input  logic [DATA_W-1:0] ctrl_datain
`ifdef LB_MASTER_STATS_EN
    ,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_wr_cnt,
    output logic [31:0]       stat_to_cnt
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_timeout;
    logic              r_ctrl_valid;
    logic              r_cs_n;
    logic              r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dout;

    logic w_accept;
    logic w_ack_done;
    logic w_to_done;
    logic w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_accept   = (r_state == ST_IDLE) && req_valid && r_req_ready;
    assign w_ack_done = (r_state == ST_ASSERT) && !ctrl_ack_n;
    assign w_to_done  = (r_state == ST_ASSERT) && ctrl_ack_n && w_cnt_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
            r_ctrl_valid  <= 1'b0;
            r_cs_n        <= 1'b1;
            r_cmd         <= 1'b0;
            r_addr        <= '0;
            r_dout        <= '0;
        end else begin
            r_ctrl_valid <= 1'b0;
            r_rsp_valid  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd        <= req_cmd;
                        r_addr       <= req_addr;
                        r_dout       <= req_cmd ? '0 : req_wdata;
                        r_cs_n       <= 1'b0;
                        r_ctrl_valid <= 1'b1;
                        r_req_ready  <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (w_ack_done) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_cmd ? ctrl_datain : '0;
                        r_cs_n        <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_RELEASE;
                    end else if (w_to_done) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '1;
                        r_cs_n        <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_RELEASE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // a stuck ack_n must not wedge the bus; give up silently
                    if (ctrl_ack_n || w_cnt_last) begin
                        r_req_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_timeout  = r_rsp_timeout;
    assign ctrl_valid   = r_ctrl_valid;
    assign ctrl_cs_n    = r_cs_n;
    assign ctrl_cmd     = r_cmd;
    assign ctrl_addr    = r_addr;
    assign ctrl_dataout = r_dout;

`ifdef LB_MASTER_STATS_EN
    logic [31:0] r_rd_cnt;
    logic [31:0] r_wr_cnt;
    logic [31:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_to_cnt <= '0;
        end else begin
            if (w_ack_done && r_cmd) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_ack_done && !r_cmd) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (w_to_done) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end
        end
    end

    assign stat_rd_cnt = r_rd_cnt;
    assign stat_wr_cnt = r_wr_cnt;
    assign stat_to_cnt = r_to_cnt;
`endif

endmodule
